// File: rtl/ipg_tx_buffer_ctrl.sv
// ipg_tx_buffer_ctrl
// Transmit-side buffering and arbitration between the MAC's 64b/66b block
// stream and memory-reply payloads sent in the inter-packet gap.
//
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   net_data_in/hdr_in    encoded block from the MAC, pushed by net_write
//   mem_data_in           520-bit memory reply, pushed by mem_write
//   mem_fin               memory side ends the current IPG burst
//   net_data_out/hdr_out  registered block to the PHY (idle block when none)
//   mem_data_out          registered memory entry to the PHY
//   ipg_en                1 = PHY transmits mem_data_out
//   tuser                 backpressure: [0] pause MAC, [1] pause memory
//   net_fin               pulse aligned with a terminate block on the outputs
//   net_/mem_ full/empty/space  FIFO status, combinational from the counts
module ipg_tx_buffer_ctrl #(
  parameter int unsigned NET_DEPTH = 4,
  parameter int unsigned MEM_DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [63:0]  net_data_in,
  input  logic [1:0]   net_hdr_in,
  input  logic         net_write,
  input  logic [519:0] mem_data_in,
  input  logic         mem_write,
  input  logic         mem_fin,
  output logic [63:0]  net_data_out,
  output logic [1:0]   net_hdr_out,
  output logic [519:0] mem_data_out,
  output logic         ipg_en,
  output logic [1:0]   tuser,
  output logic         net_fin,
  output logic         net_full,
  output logic         net_empty,
  output logic [2:0]   net_space,
  output logic         mem_full,
  output logic         mem_empty,
  output logic [2:0]   mem_space
);

  localparam int unsigned NPW = (NET_DEPTH > 1) ? $clog2(NET_DEPTH) : 1;
  localparam int unsigned MPW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  typedef enum logic {NET, IPG} state_t;

  state_t state, state_nxt;

  logic [65:0]    net_mem [NET_DEPTH];
  logic [NPW-1:0] net_wp, net_rp;
  logic [2:0]     net_cnt, net_cnt_nxt;
  logic [519:0]   mem_mem [MEM_DEPTH];
  logic [MPW-1:0] mem_wp, mem_rp;
  logic [2:0]     mem_cnt, mem_cnt_nxt;

  logic           net_pop, net_push, mem_pop, mem_push;
  logic [65:0]    net_head;
  logic           head_is_term;

  function automatic logic is_term(input logic [1:0] hdr, input logic [7:0] code);
    logic hit;
    case (code)
      8'h87, 8'h99, 8'hAA, 8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF: hit = 1'b1;
      default:                                                hit = 1'b0;
    endcase
    return (hdr == 2'b01) && hit;
  endfunction

  assign net_full  = (net_cnt == 3'(NET_DEPTH));
  assign net_empty = (net_cnt == '0);
  assign net_space = 3'(NET_DEPTH) - net_cnt;
  assign mem_full  = (mem_cnt == 3'(MEM_DEPTH));
  assign mem_empty = (mem_cnt == '0);
  assign mem_space = 3'(MEM_DEPTH) - mem_cnt;

  assign net_head     = net_mem[net_rp];
  assign head_is_term = is_term(net_head[65:64], net_head[7:0]);

  always_comb begin
    net_pop  = (state == NET) && !net_empty;
    mem_pop  = (state == IPG) && !mem_empty;
    // A full FIFO still accepts a write when it is being read the same cycle.
    net_push = net_write && (!net_full || net_pop);
    mem_push = mem_write && (!mem_full || mem_pop);

    net_cnt_nxt = net_cnt;
    if (net_push && !net_pop)      net_cnt_nxt = net_cnt + 3'd1;
    else if (!net_push && net_pop) net_cnt_nxt = net_cnt - 3'd1;

    mem_cnt_nxt = mem_cnt;
    if (mem_push && !mem_pop)      mem_cnt_nxt = mem_cnt + 3'd1;
    else if (!mem_push && mem_pop) mem_cnt_nxt = mem_cnt - 3'd1;

    state_nxt = state;
    case (state)
      NET: if (net_pop && head_is_term && (mem_cnt_nxt != '0)) state_nxt = IPG;
      IPG: if ((mem_cnt_nxt == '0) || net_full || mem_fin)     state_nxt = NET;
      default: state_nxt = NET;
    endcase
  end

  // Storage needs no reset; validity is tracked by the counts.
  always_ff @(posedge clk) begin
    if (net_push) net_mem[net_wp] <= {net_hdr_in, net_data_in};
    if (mem_push) mem_mem[mem_wp] <= mem_data_in;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= NET;
      net_wp       <= '0;
      net_rp       <= '0;
      net_cnt      <= '0;
      mem_wp       <= '0;
      mem_rp       <= '0;
      mem_cnt      <= '0;
      net_hdr_out  <= 2'b01;
      net_data_out <= 64'h1E;
      net_fin      <= 1'b0;
      mem_data_out <= '0;
      ipg_en       <= 1'b0;
      tuser        <= '0;
    end else begin
      state   <= state_nxt;
      net_cnt <= net_cnt_nxt;
      mem_cnt <= mem_cnt_nxt;
      if (net_push) net_wp <= (net_wp == NPW'(NET_DEPTH - 1)) ? '0 : net_wp + 1'b1;
      if (net_pop)  net_rp <= (net_rp == NPW'(NET_DEPTH - 1)) ? '0 : net_rp + 1'b1;
      if (mem_push) mem_wp <= (mem_wp == MPW'(MEM_DEPTH - 1)) ? '0 : mem_wp + 1'b1;
      if (mem_pop)  mem_rp <= (mem_rp == MPW'(MEM_DEPTH - 1)) ? '0 : mem_rp + 1'b1;

      if (net_pop) {net_hdr_out, net_data_out} <= net_head;
      else         {net_hdr_out, net_data_out} <= {2'b01, 64'h1E};
      net_fin <= net_pop && head_is_term;

      if (mem_pop) mem_data_out <= mem_mem[mem_rp];
      ipg_en <= mem_pop;

      // Registered from the post-edge counts so tuser lines up with *_space.
      tuser[0] <= (3'(NET_DEPTH) - net_cnt_nxt) <= 3'd1;
      tuser[1] <= (mem_cnt_nxt == 3'(MEM_DEPTH));
    end
  end

endmodule

// File: tb/tb_ipg_tx_buffer_ctrl.sv
// Directed self-checking bench for ipg_tx_buffer_ctrl (NET_DEPTH=MEM_DEPTH=4).
module tb_ipg_tx_buffer_ctrl;

  logic         clk = 1'b0;
  logic         reset;
  logic [63:0]  net_data_in;
  logic [1:0]   net_hdr_in;
  logic         net_write;
  logic [519:0] mem_data_in;
  logic         mem_write;
  logic         mem_fin;
  logic [63:0]  net_data_out;
  logic [1:0]   net_hdr_out;
  logic [519:0] mem_data_out;
  logic         ipg_en;
  logic [1:0]   tuser;
  logic         net_fin;
  logic         net_full, net_empty, mem_full, mem_empty;
  logic [2:0]   net_space, mem_space;

  int total = 0;
  int bad   = 0;

  ipg_tx_buffer_ctrl #(.NET_DEPTH(4), .MEM_DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .net_data_in(net_data_in), .net_hdr_in(net_hdr_in), .net_write(net_write),
    .mem_data_in(mem_data_in), .mem_write(mem_write), .mem_fin(mem_fin),
    .net_data_out(net_data_out), .net_hdr_out(net_hdr_out),
    .mem_data_out(mem_data_out), .ipg_en(ipg_en), .tuser(tuser), .net_fin(net_fin),
    .net_full(net_full), .net_empty(net_empty), .net_space(net_space),
    .mem_full(mem_full), .mem_empty(mem_empty), .mem_space(mem_space)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [519:0] obs, input logic [519:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [519:0] mk(input logic [63:0] top, input logic [7:0] tag);
    return {top, {57{tag}}};
  endfunction

  task automatic net_push(input logic [1:0] h, input logic [63:0] d);
    net_write   = 1'b1;
    net_hdr_in  = h;
    net_data_in = d;
  endtask

  task automatic mem_push(input logic [519:0] d);
    mem_write   = 1'b1;
    mem_data_in = d;
  endtask

  logic [519:0] m1, m2, p1, p2, p3, p4, p5, p6, x1, x2, x3, x4, x5, y1, y2, y3;

  initial begin
    m1 = mk(64'hCCCCAAAACCCCAAAA, 8'h11);
    m2 = mk(64'hDDD00DDDFFFFFFFF, 8'h22);
    p1 = mk(64'h0000000000000001, 8'h31);
    p2 = mk(64'h0000000000000002, 8'h32);
    p3 = mk(64'h0000000000000003, 8'h33);
    p4 = mk(64'h0000000000000004, 8'h34);
    p5 = mk(64'h0000000000000005, 8'h35);
    p6 = mk(64'h0000000000000006, 8'h36);
    x1 = mk(64'hA1A1A1A1A1A1A1A1, 8'h41);
    x2 = mk(64'hA2A2A2A2A2A2A2A2, 8'h42);
    x3 = mk(64'hA3A3A3A3A3A3A3A3, 8'h43);
    x4 = mk(64'hA4A4A4A4A4A4A4A4, 8'h44);
    x5 = mk(64'hA5A5A5A5A5A5A5A5, 8'h45);
    y1 = mk(64'hB1B1B1B1B1B1B1B1, 8'h51);
    y2 = mk(64'hB2B2B2B2B2B2B2B2, 8'h52);
    y3 = mk(64'hB3B3B3B3B3B3B3B3, 8'h53);

    reset = 1'b1;
    net_data_in = '0; net_hdr_in = '0; net_write = 1'b0;
    mem_data_in = '0; mem_write = 1'b0; mem_fin = 1'b0;

    // 1: reset state
    #2 reset = 1'b0;
    tick(); tick();
    chk("rst_hdr",       520'(net_hdr_out),  520'(2'b01));
    chk("rst_data",      520'(net_data_out), 520'(64'h1E));
    chk("rst_net_space", 520'(net_space),    520'(3'd4));
    chk("rst_mem_space", 520'(mem_space),    520'(3'd4));
    chk("rst_empties",   520'({net_empty, mem_empty}), 520'(2'b11));
    chk("rst_fulls",     520'({net_full, mem_full}),   520'(2'b00));
    chk("rst_ipg_en",    520'(ipg_en),  520'(1'b0));
    chk("rst_tuser",     520'(tuser),   520'(2'b00));
    chk("rst_net_fin",   520'(net_fin), 520'(1'b0));
    chk("rst_mem_out",   mem_data_out,  '0);
    reset = 1'b1;
    tick();
    chk("rel_data",  520'(net_data_out), 520'(64'h1E));
    chk("rel_ipg",   520'(ipg_en),       520'(1'b0));

    // 2: data block, terminate, then a data block whose low byte looks like a terminate code
    net_push(2'b10, 64'hBB11223344556677);
    tick();
    chk("t2a_hdr_idle",  520'(net_hdr_out), 520'(2'b01));
    chk("t2a_net_space", 520'(net_space),   520'(3'd3));
    net_push(2'b01, 64'hAA99);
    tick();
    chk("t2b_hdr",  520'(net_hdr_out),  520'(2'b10));
    chk("t2b_data", 520'(net_data_out), 520'(64'hBB11223344556677));
    chk("t2b_fin",  520'(net_fin),      520'(1'b0));
    net_push(2'b10, 64'h87);
    tick();
    chk("t2c_hdr",  520'(net_hdr_out),  520'(2'b01));
    chk("t2c_data", 520'(net_data_out), 520'(64'hAA99));
    chk("t2c_fin",  520'(net_fin),      520'(1'b1));
    chk("t2c_ipg",  520'(ipg_en),       520'(1'b0));
    net_write = 1'b0;
    tick();
    chk("t2d_data",  520'(net_data_out), 520'(64'h87));
    chk("t2d_fin",   520'(net_fin),      520'(1'b0));
    chk("t2d_ipg",   520'(ipg_en),       520'(1'b0));
    chk("t2d_empty", 520'(net_empty),    520'(1'b1));
    tick();
    chk("t2e_idle", 520'(net_data_out), 520'(64'h1E));

    // 3: two memory entries sent after a terminate; queued network block waits
    mem_push(m1); tick();
    mem_push(m2); tick();
    mem_write = 1'b0;
    chk("t3_mem_space", 520'(mem_space), 520'(3'd2));
    net_push(2'b01, 64'h87); tick();
    net_push(2'b10, 64'h1234); tick();
    chk("t3f_data", 520'(net_data_out), 520'(64'h87));
    chk("t3f_fin",  520'(net_fin),      520'(1'b1));
    chk("t3f_ipg",  520'(ipg_en),       520'(1'b0));
    net_write = 1'b0;
    tick();
    chk("t3g_ipg",       520'(ipg_en),       520'(1'b1));
    chk("t3g_mem",       mem_data_out,       m1);
    chk("t3g_idle",      520'(net_data_out), 520'(64'h1E));
    chk("t3g_fin",       520'(net_fin),      520'(1'b0));
    chk("t3g_net_space", 520'(net_space),    520'(3'd3));
    tick();
    chk("t3h_ipg",       520'(ipg_en),    520'(1'b1));
    chk("t3h_mem",       mem_data_out,    m2);
    chk("t3h_mem_empty", 520'(mem_empty), 520'(1'b1));
    chk("t3h_net_space", 520'(net_space), 520'(3'd3));
    tick();
    chk("t3i_ipg",      520'(ipg_en),       520'(1'b0));
    chk("t3i_hdr",      520'(net_hdr_out),  520'(2'b10));
    chk("t3i_data",     520'(net_data_out), 520'(64'h1234));
    chk("t3i_mem_hold", mem_data_out,       m2);
    tick();
    chk("t3j_idle", 520'(net_data_out), 520'(64'h1E));

    // 4: fill the network FIFO during IPG (memory kept topped up)
    mem_push(p1); tick();
    mem_push(p2); tick();
    mem_write = 1'b0;
    net_push(2'b01, 64'hCC); tick();
    net_write = 1'b0;
    tick();
    chk("t4k_fin", 520'(net_fin), 520'(1'b1));
    net_push(2'b10, 64'h1); mem_push(p3); tick();
    chk("t4l1_ipg",   520'(ipg_en),    520'(1'b1));
    chk("t4l1_mem",   mem_data_out,    p1);
    chk("t4l1_space", 520'(net_space), 520'(3'd3));
    chk("t4l1_tuser", 520'(tuser),     520'(2'b00));
    net_push(2'b10, 64'h2); mem_push(p4); tick();
    chk("t4l2_mem",   mem_data_out,    p2);
    chk("t4l2_space", 520'(net_space), 520'(3'd2));
    chk("t4l2_tuser", 520'(tuser),     520'(2'b00));
    net_push(2'b10, 64'h3); mem_push(p5); tick();
    chk("t4l3_mem",   mem_data_out,    p3);
    chk("t4l3_space", 520'(net_space), 520'(3'd1));
    chk("t4l3_tuser", 520'(tuser),     520'(2'b01));
    net_push(2'b10, 64'h4); mem_push(p6); tick();
    chk("t4l4_mem",       mem_data_out,    p4);
    chk("t4l4_full",      520'(net_full),  520'(1'b1));
    chk("t4l4_space",     520'(net_space), 520'(3'd0));
    chk("t4l4_tuser",     520'(tuser),     520'(2'b01));
    chk("t4l4_ipg",       520'(ipg_en),    520'(1'b1));
    chk("t4l4_mem_space", 520'(mem_space), 520'(3'd2));
    net_write = 1'b0; mem_write = 1'b0;
    tick();
    chk("t4l5_ipg",       520'(ipg_en),       520'(1'b1));
    chk("t4l5_mem",       mem_data_out,       p5);
    chk("t4l5_mem_space", 520'(mem_space),    520'(3'd3));
    chk("t4l5_idle",      520'(net_data_out), 520'(64'h1E));
    tick();
    chk("t4l6_ipg",       520'(ipg_en),       520'(1'b0));
    chk("t4l6_data",      520'(net_data_out), 520'(64'h1));
    chk("t4l6_space",     520'(net_space),    520'(3'd1));
    chk("t4l6_tuser",     520'(tuser),        520'(2'b01));
    chk("t4l6_mem_space", 520'(mem_space),    520'(3'd3));
    chk("t4l6_mem_hold",  mem_data_out,       p5);
    tick();
    chk("t4l7_data",  520'(net_data_out), 520'(64'h2));
    chk("t4l7_tuser", 520'(tuser),        520'(2'b00));
    tick();
    chk("t4l8_data", 520'(net_data_out), 520'(64'h3));
    tick();
    chk("t4l9_data", 520'(net_data_out), 520'(64'h4));
    tick();
    chk("t4l10_idle", 520'(net_data_out), 520'(64'h1E));

    // 5: overfill memory FIFO, then drain it to show the 5th entry was dropped
    reset = 1'b0; tick(); reset = 1'b1;
    chk("t5_rst_mem_space", 520'(mem_space), 520'(3'd4));
    mem_push(x1); tick();
    mem_push(x2); tick();
    mem_push(x3); tick();
    mem_push(x4); tick();
    chk("t5_full4",  520'(mem_full),  520'(1'b1));
    chk("t5_space4", 520'(mem_space), 520'(3'd0));
    chk("t5_tuser4", 520'(tuser),     520'(2'b10));
    mem_push(x5); tick();
    mem_write = 1'b0;
    chk("t5_full5",  520'(mem_full),  520'(1'b1));
    chk("t5_space5", 520'(mem_space), 520'(3'd0));
    net_push(2'b01, 64'hFF); tick();
    net_write = 1'b0;
    tick();
    chk("t5_fin", 520'(net_fin), 520'(1'b1));
    tick();
    chk("t5_pop1",   mem_data_out, x1);
    chk("t5_tuser1", 520'(tuser),  520'(2'b00));
    tick();
    chk("t5_pop2", mem_data_out, x2);
    tick();
    chk("t5_pop3", mem_data_out, x3);
    tick();
    chk("t5_pop4",  mem_data_out,    x4);
    chk("t5_empty", 520'(mem_empty), 520'(1'b1));
    chk("t5_ipg4",  520'(ipg_en),    520'(1'b1));
    tick();
    chk("t5_exit_ipg", 520'(ipg_en), 520'(1'b0));
    chk("t5_no_x5",    mem_data_out, x4);

    // 6: mem_fin cuts a 3-entry burst after the first pop
    mem_push(y1); tick();
    mem_push(y2); tick();
    mem_push(y3); tick();
    mem_write = 1'b0;
    chk("t6_space3", 520'(mem_space), 520'(3'd1));
    net_push(2'b01, 64'hE1); tick();
    net_write = 1'b0;
    tick();
    chk("t6_fin", 520'(net_fin), 520'(1'b1));
    mem_fin = 1'b1;
    tick();
    chk("t6_ipg",   520'(ipg_en),    520'(1'b1));
    chk("t6_mem",   mem_data_out,    y1);
    chk("t6_space", 520'(mem_space), 520'(3'd2));
    mem_fin = 1'b0;
    tick();
    chk("t6_exit_ipg",   520'(ipg_en),    520'(1'b0));
    chk("t6_kept_space", 520'(mem_space), 520'(3'd2));
    chk("t6_mem_hold",   mem_data_out,    y1);
    tick();
    chk("t6_stay_net", 520'(ipg_en), 520'(1'b0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ipg_tx_buffer_ctrl.md
Name: ipg_tx_buffer_ctrl

Overview:
- Transmit-side buffering and arbitration between the MAC's 64b/66b encoded stream and memory-reply payloads that are sent in the inter-packet gap (IPG).
- Contains a network FIFO (66-bit blocks) and a memory FIFO (520-bit replies), plus a monitor FSM.
- The FSM forwards network blocks by default. After a frame terminates it switches to memory entries when any are queued, and drives backpressure to both producers.

Parameters:
- NET_DEPTH, 4, network FIFO entries (power of 2, at most 7).
- MEM_DEPTH, 4, memory FIFO entries (power of 2, at most 7).

Ports:
- clk  in  1  single clock, all logic rising-edge.
- reset  in  1  asynchronous, active-low reset.
- net_data_in  in  64  encoded block payload from the MAC.
- net_hdr_in  in  2  sync header: 2'b10 data, 2'b01 control.
- net_write  in  1  push {hdr,data} into the network FIFO.
- mem_data_in  in  520  memory reply.
- mem_write  in  1  push a reply into the memory FIFO.
- mem_fin  in  1  memory side aborts or ends the current IPG burst.
- net_data_out  out  64  registered block to the PHY.
- net_hdr_out  out  2  registered sync header to the PHY.
- mem_data_out  out  520  registered memory entry to the PHY.
- ipg_en  out  1  1 = PHY transmits mem_data_out; 0 = PHY transmits the network block.
- tuser  out  2  backpressure: [0] pause MAC, [1] pause memory.
- net_fin  out  1  one-cycle pulse: a terminate block was just issued.
- net_full, net_empty  out  1 each  network FIFO status.
- net_space  out  3  NET_DEPTH minus occupancy.
- mem_full, mem_empty  out  1 each  memory FIFO status.
- mem_space  out  3  MEM_DEPTH minus occupancy.

Behaviour:

Reset (while reset=0):
- Both FIFOs are empty.
- net_space=NET_DEPTH and mem_space=MEM_DEPTH.
- empty flags are 1 and full flags are 0.
- ipg_en=0, tuser=0, net_fin=0, mem_data_out=0.
- Network outputs show the idle block: hdr=2'b01, data=64'h1E.
- FSM is in state NET.

FIFOs:
- Each FIFO is circular, with read and write pointers plus a count.
- A write is accepted when its write strobe is 1 and the FIFO is not full, or when it is full and a read occurs in the same cycle.
- A read never occurs when the FIFO is empty.
- Simultaneous read and write leaves the count unchanged.
- Pointers wrap modulo the depth.
- An entry written in cycle N is poppable from cycle N+1.
- Status outputs (full, empty, space) are combinational from the count.

Network output register (updated every cycle):
- In NET with the network FIFO non-empty: pop the head into net_hdr_out/net_data_out.
- Otherwise: load the idle block. In IPG the network FIFO is not popped.

Terminate detection:
- A popped block is a terminate block when hdr=2'b01 and data[7:0] is one of 87, 99, AA, B4, CC, D2, E1 or FF (hex).
- net_fin is registered and is 1 in exactly the cycle that block appears on the outputs.

FSM states: NET, IPG.
- NET→IPG at the edge where a terminate block is popped, provided the memory FIFO is non-empty after that edge's write is accounted for (a write in the same cycle counts).
- In IPG, each cycle pops one memory entry into mem_data_out, and ipg_en=1.
- IPG→NET when any of the following holds after the current pop: the memory FIFO is empty, net_full=1, or mem_fin=1.
- If the memory FIFO is empty on entry, the FSM stays in NET.

Outputs outside IPG:
- mem_data_out holds its last value.
- ipg_en=0.

Backpressure:
- tuser[0]=1 when net_space≤1.
- tuser[1]=1 when mem_space==0.
- Both bits are registered.

Test Plan:
1. Reset, then release → idle block on the outputs, spaces 4/4, ipg_en=0, tuser=0, net_fin=0.
2. Write data block {10, 64'hBB11223344556677}, then control block {01, 64'hAA99} → both appear in order one cycle after the pushes; net_fin pulses with 64'hAA99; memory FIFO empty so ipg_en stays 0.
3. Preload 2 memory entries (top 64 bits CCCCAAAACCCCAAAA and DDD00DDDFFFFFFFF), then send a terminate block → ipg_en=1 for exactly 2 cycles with the entries in order; the network FIFO is not popped; then NET resumes with the idle block.
4. While in IPG, push network blocks until net_full=1 → return to NET the next cycle; tuser[0]=1 while net_space≤1; the remaining memory entry is kept.
5. Write 5 memory entries into MEM_DEPTH=4 → 5th is dropped; mem_full=1, mem_space=0, tuser[1]=1.
6. Assert mem_fin during a 3-entry IPG burst → exits after the current pop; 2 entries remain (mem_space=2).
